// File: rtl/cp0_tlb_seq_pkg.sv
// Shared definitions for the CP0 TLB-instruction sequencer.
// Contents:
//   - TLB instruction encodings carried on op_type.
//   - Sequencer state encodings.
//   - Packed 78-bit TLB entry layout: width, a packed struct and the bit offset
//     of every field.
package cp0_tlb_seq_pkg;

  localparam int ENTRY_W = 78;

  localparam logic [1:0] OP_TLBP  = 2'd0;
  localparam logic [1:0] OP_TLBR  = 2'd1;
  localparam logic [1:0] OP_TLBWI = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXEC    = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;
  localparam logic [1:0] ST_REFETCH = 2'd3;

  // Field offsets (LSB position) inside the packed entry.
  localparam int E_V1   = 0;
  localparam int E_D1   = 1;
  localparam int E_C1   = 2;
  localparam int E_PFN1 = 5;
  localparam int E_V0   = 25;
  localparam int E_D0   = 26;
  localparam int E_C0   = 27;
  localparam int E_PFN0 = 30;
  localparam int E_G    = 50;
  localparam int E_ASID = 51;
  localparam int E_VPN2 = 59;

  // Declared MSB first, so the packed struct matches the offsets above.
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

endpackage

// File: rtl/cp0_tlb_seq_if.sv
// TLB port bundle between the sequencer (master) and the TLB array (slave).
// Signals:
//   - Search port: s_vpn2, s_asid out; s_found, s_index back.
//     The TLB resolves the search combinationally.
//   - Read port: r_index out; r_entry back, combinational.
//   - Write port: w_we, w_index, w_entry out.
interface cp0_tlb_seq_if #(
  parameter int IDX_W = 4
);
  import cp0_tlb_seq_pkg::*;

  logic [18:0]        s_vpn2;
  logic [7:0]         s_asid;
  logic               s_found;
  logic [IDX_W-1:0]   s_index;
  logic [IDX_W-1:0]   r_index;
  logic [ENTRY_W-1:0] r_entry;
  logic               w_we;
  logic [IDX_W-1:0]   w_index;
  logic [ENTRY_W-1:0] w_entry;

  modport master (
    output s_vpn2, s_asid, r_index, w_we, w_index, w_entry,
    input  s_found, s_index, r_entry
  );

  modport slave (
    input  s_vpn2, s_asid, r_index, w_we, w_index, w_entry,
    output s_found, s_index, r_entry
  );

endinterface

// File: rtl/tlb_entry_pack.sv
// Combinational packing of CP0 EntryHi/EntryLo0/EntryLo1 into a 78-bit TLB
// entry. The same block serves the CP0-side unpacking checks.
// Ports:
//   entryhi, entrylo0, entrylo1 : CP0 register values (in)
//   entry                       : packed entry (out)
module tlb_entry_pack
  import cp0_tlb_seq_pkg::*;
(
  input  logic [31:0]        entryhi,
  input  logic [31:0]        entrylo0,
  input  logic [31:0]        entrylo1,
  output logic [ENTRY_W-1:0] entry
);

  tlb_entry_t e;

  always_comb begin
    e.vpn2 = entryhi[31:13];
    e.asid = entryhi[7:0];
    // The entry is global only if both halves carry G.
    e.g    = entrylo0[0] & entrylo1[0];
    e.pfn0 = entrylo0[25:6];
    e.c0   = entrylo0[5:3];
    e.d0   = entrylo0[2];
    e.v0   = entrylo0[1];
    e.pfn1 = entrylo1[25:6];
    e.c1   = entrylo1[5:3];
    e.d1   = entrylo1[2];
    e.v1   = entrylo1[1];
  end

  assign entry = e;

  // Reserved register bits have no home in the entry.
  logic unused_pack_bits;
  assign unused_pack_bits = ^{entryhi[12:8], entrylo0[31:26], entrylo1[31:26]};

endmodule

// File: rtl/cp0_tlb_seq.sv
// Multi-cycle sequencer for TLBP / TLBR / TLBWI, issued from WB.
// Operation:
//   - Drives the TLB search/read/write ports from CP0 EntryHi, EntryLo0/1 and
//     Index.
//   - Returns TLBP/TLBR results to CP0 as single-cycle pulses.
//   - Stalls the pipeline while an op is in flight.
//   - Finishes with a refetch pulse at op_pc+4, so later fetches see the new
//     mapping.
// Ports:
//   clk, reset (sync, active-high)
//   op_valid, op_type, op_pc, wb_ex                : WB-stage instruction
//   c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index : CP0 register values
//   tlb (cp0_tlb_seq_if.master)                    : TLB search/read/write ports
//   cp0_tlbp, cp0_tlbp_found, cp0_index            : TLBP result pulse
//   cp0_tlbr, cp0_rentry                           : TLBR result pulse
//   busy                                           : pipeline stall
//   refetch, refetch_pc                            : flush/restart request
module cp0_tlb_seq
  import cp0_tlb_seq_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = $clog2(TLBNUM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [1:0]         op_type,
  input  logic [31:0]        op_pc,
  input  logic               wb_ex,
  input  logic [31:0]        c0_entryhi,
  input  logic [31:0]        c0_entrylo0,
  input  logic [31:0]        c0_entrylo1,
  input  logic [31:0]        c0_index,
  cp0_tlb_seq_if.master      tlb,
  output logic               cp0_tlbp,
  output logic               cp0_tlbp_found,
  output logic [IDX_W-1:0]   cp0_index,
  output logic               cp0_tlbr,
  output logic [ENTRY_W-1:0] cp0_rentry,
  output logic               busy,
  output logic               refetch,
  output logic [31:0]        refetch_pc
);

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q;
  logic [31:0]        refetch_pc_q;
  logic               found_q;
  logic [IDX_W-1:0]   index_q;
  logic [ENTRY_W-1:0] entry_q;
  logic               accept;
  logic               in_exec;

  // Only an idle sequencer takes a new op; ops hit by an exception and the
  // reserved encoding are dropped.
  assign accept  = (state_q == ST_IDLE) && op_valid && !wb_ex && (op_type != OP_RSVD);
  assign in_exec = (state_q == ST_EXEC);

  always_comb begin
    // NOTE: default first, so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_EXEC;
      // TLBWI has nothing to report to CP0, so it skips COMMIT.
      ST_EXEC:    state_d = (op_q == OP_TLBWI) ? ST_REFETCH : ST_COMMIT;
      ST_COMMIT:  state_d = ST_REFETCH;
      ST_REFETCH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking throughout, so every register samples pre-edge values.
      state_q      <= ST_IDLE;
      op_q         <= OP_TLBP;
      refetch_pc_q <= '0;
      found_q      <= 1'b0;
      index_q      <= '0;
      entry_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q         <= op_type;
        refetch_pc_q <= op_pc + 32'd4;
      end
      if (in_exec && (op_q == OP_TLBP)) begin
        found_q <= tlb.s_found;
        index_q <= tlb.s_index;
      end
      if (in_exec && (op_q == OP_TLBR)) begin
        entry_q <= tlb.r_entry;
      end
    end
  end

  // Search and read ports follow CP0 at all times; they have no side effects.
  assign tlb.s_vpn2  = c0_entryhi[31:13];
  assign tlb.s_asid  = c0_entryhi[7:0];
  assign tlb.r_index = c0_index[IDX_W-1:0];
  assign tlb.w_index = c0_index[IDX_W-1:0];

  tlb_entry_pack u_pack (
    .entryhi  (c0_entryhi),
    .entrylo0 (c0_entrylo0),
    .entrylo1 (c0_entrylo1),
    .entry    (tlb.w_entry)
  );

  // Every pulse is gated by reset. A reset that lands mid-op therefore emits
  // no write and no CP0 update in that cycle.
  assign tlb.w_we = !reset && in_exec && (op_q == OP_TLBWI);
  assign cp0_tlbp = !reset && (state_q == ST_COMMIT) && (op_q == OP_TLBP);
  assign cp0_tlbr = !reset && (state_q == ST_COMMIT) && (op_q == OP_TLBR);
  assign refetch  = !reset && (state_q == ST_REFETCH);
  // busy also covers the accept cycle, so WB holds the instruction there.
  assign busy     = !reset && ((state_q != ST_IDLE) || accept);

  assign cp0_tlbp_found = found_q;
  assign cp0_index      = index_q;
  assign cp0_rentry     = entry_q;
  assign refetch_pc     = refetch_pc_q;

  logic unused_index_bits;
  assign unused_index_bits = ^c0_index[31:IDX_W];

endmodule

// File: tb/tb_cp0_tlb_seq.sv
// Self-checking bench for cp0_tlb_seq.
// Test phases:
//   - Table of directed ops.
//   - Hand sequences for dropped ops, wb_ex during EXEC, and reset in COMMIT.
//   - Random stimulus checked against a timeline model: an accepted op
//     produces fixed events at fixed offsets from its accept cycle.
module tb_cp0_tlb_seq;
  import cp0_tlb_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] op_pc;
  logic        wb_ex;
  logic [31:0] c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index;
  logic        cp0_tlbp, cp0_tlbp_found, cp0_tlbr, busy, refetch;
  logic [3:0]  cp0_index;
  logic [77:0] cp0_rentry;
  logic [31:0] refetch_pc;

  cp0_tlb_seq_if #(.IDX_W(4)) tlb_bus ();

  cp0_tlb_seq #(.TLBNUM(16), .IDX_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .op_valid       (op_valid),
    .op_type        (op_type),
    .op_pc          (op_pc),
    .wb_ex          (wb_ex),
    .c0_entryhi     (c0_entryhi),
    .c0_entrylo0    (c0_entrylo0),
    .c0_entrylo1    (c0_entrylo1),
    .c0_index       (c0_index),
    .tlb            (tlb_bus),
    .cp0_tlbp       (cp0_tlbp),
    .cp0_tlbp_found (cp0_tlbp_found),
    .cp0_index      (cp0_index),
    .cp0_tlbr       (cp0_tlbr),
    .cp0_rentry     (cp0_rentry),
    .busy           (busy),
    .refetch        (refetch),
    .refetch_pc     (refetch_pc)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Inputs change at posedge+1; outputs are sampled at posedge+2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input logic [1:0] op);
    return (op == OP_TLBWI) ? 2 : 3;
  endfunction

  function automatic logic [77:0] ref_entry(input logic [31:0] hi, lo0, lo1);
    return {hi[31:13], hi[7:0], lo0[0] & lo1[0],
            lo0[25:6], lo0[5:3], lo0[2], lo0[1],
            lo1[25:6], lo1[5:3], lo1[2], lo1[1]};
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".busy"},    busy,           1'b0);
    check({tag, ".w_we"},    tlb_bus.w_we,   1'b0);
    check({tag, ".tlbp"},    cp0_tlbp,       1'b0);
    check({tag, ".tlbr"},    cp0_tlbr,       1'b0);
    check({tag, ".refetch"}, refetch,        1'b0);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] pc, hi, lo0, lo1, idx;
    logic        found;
    logic [3:0]  sidx;
    logic [77:0] rent;
    logic [18:0] x_vpn2;
    logic [7:0]  x_asid;
    logic [3:0]  x_ridx;
    logic        x_found;
    logic [3:0]  x_index;
    logic [77:0] x_entry;
    logic [31:0] x_rpc;
  } vec_t;

  vec_t vecs[5];

  // Starts at posedge+1 with the sequencer idle; ends at posedge+1, idle again.
  task automatic run_vec(input vec_t v);
    int lat = lat_of(v.op);
    op_valid = 1'b1; op_type = v.op; op_pc = v.pc; wb_ex = 1'b0;
    c0_entryhi = v.hi; c0_entrylo0 = v.lo0; c0_entrylo1 = v.lo1; c0_index = v.idx;
    tlb_bus.s_found = v.found; tlb_bus.s_index = v.sidx; tlb_bus.r_entry = v.rent;
    #1;
    check({v.name, ".accept_busy"}, busy,            1'b1);
    check({v.name, ".s_vpn2"},      tlb_bus.s_vpn2,  v.x_vpn2);
    check({v.name, ".s_asid"},      tlb_bus.s_asid,  v.x_asid);
    check({v.name, ".r_index"},     tlb_bus.r_index, v.x_ridx);
    for (int d = 1; d <= lat + 1; d++) begin
      tick();
      if (d == lat + 1) op_valid = 1'b0;
      #1;
      check($sformatf("%s.busy@%0d", v.name, d),    busy,         d <= lat);
      check($sformatf("%s.w_we@%0d", v.name, d),    tlb_bus.w_we, (v.op == OP_TLBWI) && d == 1);
      check($sformatf("%s.tlbp@%0d", v.name, d),    cp0_tlbp,     (v.op == OP_TLBP) && d == 2);
      check($sformatf("%s.tlbr@%0d", v.name, d),    cp0_tlbr,     (v.op == OP_TLBR) && d == 2);
      check($sformatf("%s.refetch@%0d", v.name, d), refetch,      d == lat);
      if (v.op == OP_TLBWI && d == 1) begin
        check({v.name, ".w_index"}, tlb_bus.w_index, v.x_ridx);
        check({v.name, ".w_entry"}, tlb_bus.w_entry, v.x_entry);
      end
      if (v.op == OP_TLBP && d == 2) begin
        check({v.name, ".found"}, cp0_tlbp_found, v.x_found);
        check({v.name, ".index"}, cp0_index,      v.x_index);
      end
      if (v.op == OP_TLBR && d == 2) check({v.name, ".rentry"}, cp0_rentry, v.x_entry);
      if (d == lat) check({v.name, ".refetch_pc"}, refetch_pc, v.x_rpc);
    end
    tick();
  endtask

  // Random-phase model state.
  bit          m_active;
  int          m_t_acc;
  logic [1:0]  m_op;
  logic [31:0] m_pc4;
  logic        m_found;
  logic [3:0]  m_idx;
  logic [77:0] m_rent;

  initial begin
    vecs[0] = '{name:"tlbp_hit", op:OP_TLBP, pc:32'hBFC0_0100, hi:32'h0040_2005,
                lo0:32'h0, lo1:32'h0, idx:32'h1, found:1'b1, sidx:4'd7, rent:78'h0,
                x_vpn2:19'h00201, x_asid:8'h05, x_ridx:4'd1, x_found:1'b1, x_index:4'd7,
                x_entry:78'h0, x_rpc:32'hBFC0_0104};
    vecs[1] = '{name:"tlbp_miss", op:OP_TLBP, pc:32'h0040_0200, hi:32'hFFFF_E0FF,
                lo0:32'h0, lo1:32'h0, idx:32'h2, found:1'b0, sidx:4'hA, rent:78'h0,
                x_vpn2:19'h7FFFF, x_asid:8'hFF, x_ridx:4'd2, x_found:1'b0, x_index:4'hA,
                x_entry:78'h0, x_rpc:32'h0040_0204};
    vecs[2] = '{name:"tlbwi", op:OP_TLBWI, pc:32'h0000_2000, hi:32'h1234_6001,
                lo0:32'h0000_1047, lo1:32'h0000_1087, idx:32'h3, found:1'b0, sidx:4'h0,
                rent:78'h0, x_vpn2:19'h091A3, x_asid:8'h01, x_ridx:4'd3, x_found:1'b0,
                x_index:4'h0,
                x_entry:{19'h091A3, 8'h01, 1'b1, 20'h00041, 3'd0, 1'b1, 1'b1,
                         20'h00042, 3'd0, 1'b1, 1'b1},
                x_rpc:32'h0000_2004};
    vecs[3] = '{name:"tlbr", op:OP_TLBR, pc:32'h8000_0FFC, hi:32'h0, lo0:32'h0, lo1:32'h0,
                idx:32'h8000_0015, found:1'b0, sidx:4'h0, rent:{39{2'b10}},
                x_vpn2:19'h0, x_asid:8'h0, x_ridx:4'd5, x_found:1'b0, x_index:4'h0,
                x_entry:{39{2'b10}}, x_rpc:32'h8000_1000};
    vecs[4] = '{name:"tlbwi_ng_wrap", op:OP_TLBWI, pc:32'hFFFF_FFFC, hi:32'hFFFF_E0AB,
                lo0:32'h03FF_FFFF, lo1:32'h0000_0006, idx:32'h1F, found:1'b0, sidx:4'h0,
                rent:78'h0, x_vpn2:19'h7FFFF, x_asid:8'hAB, x_ridx:4'hF, x_found:1'b0,
                x_index:4'h0,
                x_entry:{19'h7FFFF, 8'hAB, 1'b0, 20'hFFFFF, 3'd7, 1'b1, 1'b1,
                         20'h00000, 3'd0, 1'b1, 1'b1},
                x_rpc:32'h0000_0000};

    // Reset, with op_valid asserted to show it is ignored during reset.
    reset = 1'b1; op_valid = 1'b1; op_type = OP_TLBWI; op_pc = 32'h100; wb_ex = 1'b0;
    c0_entryhi = '0; c0_entrylo0 = '0; c0_entrylo1 = '0; c0_index = '0;
    tlb_bus.s_found = 1'b0; tlb_bus.s_index = '0; tlb_bus.r_entry = '0;
    tick(); tick();
    #1;
    check_quiet("reset");
    tick();
    reset = 1'b0; op_valid = 1'b0;
    #1;
    check_quiet("post_reset");
    check("post_reset.refetch_pc", refetch_pc,     32'h0);
    check("post_reset.found",      cp0_tlbp_found, 1'b0);
    check("post_reset.index",      cp0_index,      4'h0);
    check("post_reset.rentry",     cp0_rentry,     78'h0);
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // op_valid together with wb_ex: the op is dropped.
    op_valid = 1'b1; op_type = OP_TLBWI; wb_ex = 1'b1; op_pc = 32'h4000;
    #1; check("drop.busy", busy, 1'b0);
    tick(); op_valid = 1'b0; wb_ex = 1'b0;
    #1; check_quiet("drop.next");
    tick();

    // Reserved op_type is ignored.
    op_valid = 1'b1; op_type = OP_RSVD;
    #1; check("rsvd.busy", busy, 1'b0);
    tick(); op_valid = 1'b0;
    #1; check_quiet("rsvd.next");
    tick();

    // wb_ex raised during EXEC: the op still completes.
    op_valid = 1'b1; op_type = OP_TLBP; op_pc = 32'h0000_3000;
    tlb_bus.s_found = 1'b1; tlb_bus.s_index = 4'hC;
    #1; check("exec_ex.accept_busy", busy, 1'b1);
    tick(); wb_ex = 1'b1;
    #1; check("exec_ex.busy1", busy, 1'b1);
    tick(); wb_ex = 1'b0;
    #1;
    check("exec_ex.tlbp",  cp0_tlbp,       1'b1);
    check("exec_ex.found", cp0_tlbp_found, 1'b1);
    check("exec_ex.index", cp0_index,      4'hC);
    tick(); op_valid = 1'b0;
    #1;
    check("exec_ex.refetch",    refetch,    1'b1);
    check("exec_ex.refetch_pc", refetch_pc, 32'h0000_3004);
    tick();
    #1; check_quiet("exec_ex.done");
    tick();

    // Reset asserted in COMMIT: no pulse, then idle with cleared registers.
    op_valid = 1'b1; op_type = OP_TLBP; op_pc = 32'h1234_5670;
    tlb_bus.s_found = 1'b1; tlb_bus.s_index = 4'h9;
    tick();                 // EXEC
    tick(); reset = 1'b1;   // COMMIT, reset asserted
    #1; check_quiet("rst_commit");
    tick(); reset = 1'b0; op_valid = 1'b0;
    #1;
    check_quiet("rst_commit.next");
    check("rst_commit.found",      cp0_tlbp_found, 1'b0);
    check("rst_commit.index",      cp0_index,      4'h0);
    check("rst_commit.refetch_pc", refetch_pc,     32'h0);
    tick();
    run_vec(vecs[2]);

    // Random stimulus against the timeline model.
    m_active = 1'b0; m_t_acc = 0; m_op = OP_TLBP; m_pc4 = '0;
    m_found = 1'b0; m_idx = '0; m_rent = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [95:0] rnd;
      int d, lat;
      bit exp_wwe, exp_p, exp_r, exp_ref;
      op_valid    = ($urandom_range(0, 1) == 1);
      op_type     = 2'($urandom_range(0, 3));
      op_pc       = $urandom() & 32'hFFFF_FFFC;
      wb_ex       = ($urandom_range(0, 3) == 0);
      c0_entryhi  = $urandom();
      c0_entrylo0 = $urandom();
      c0_entrylo1 = $urandom();
      c0_index    = $urandom();
      tlb_bus.s_found = ($urandom_range(0, 1) == 1);
      tlb_bus.s_index = 4'($urandom_range(0, 15));
      rnd = {$urandom(), $urandom(), $urandom()};
      tlb_bus.r_entry = rnd[77:0];
      #1;
      d = cyc - m_t_acc;
      if (m_active && d > lat_of(m_op)) m_active = 1'b0;
      if (!m_active && op_valid && !wb_ex && op_type != OP_RSVD) begin
        m_active = 1'b1; m_t_acc = cyc; m_op = op_type; m_pc4 = op_pc + 32'd4; d = 0;
      end
      lat     = lat_of(m_op);
      exp_wwe = m_active && m_op == OP_TLBWI && d == 1;
      exp_p   = m_active && m_op == OP_TLBP && d == 2;
      exp_r   = m_active && m_op == OP_TLBR && d == 2;
      exp_ref = m_active && d == lat;
      check($sformatf("rnd%0d.busy", cyc),    busy,         m_active);
      check($sformatf("rnd%0d.w_we", cyc),    tlb_bus.w_we, exp_wwe);
      check($sformatf("rnd%0d.tlbp", cyc),    cp0_tlbp,     exp_p);
      check($sformatf("rnd%0d.tlbr", cyc),    cp0_tlbr,     exp_r);
      check($sformatf("rnd%0d.refetch", cyc), refetch,      exp_ref);
      check($sformatf("rnd%0d.search", cyc),  {tlb_bus.s_vpn2, tlb_bus.s_asid, tlb_bus.r_index},
            {c0_entryhi[31:13], c0_entryhi[7:0], c0_index[3:0]});
      if (exp_wwe) begin
        check($sformatf("rnd%0d.w_index", cyc), tlb_bus.w_index, c0_index[3:0]);
        check($sformatf("rnd%0d.w_entry", cyc), tlb_bus.w_entry,
              ref_entry(c0_entryhi, c0_entrylo0, c0_entrylo1));
      end
      if (exp_p) begin
        check($sformatf("rnd%0d.found", cyc), cp0_tlbp_found, m_found);
        check($sformatf("rnd%0d.index", cyc), cp0_index,      m_idx);
      end
      if (exp_r) check($sformatf("rnd%0d.rentry", cyc), cp0_rentry, m_rent);
      if (exp_ref) check($sformatf("rnd%0d.refetch_pc", cyc), refetch_pc, m_pc4);
      // The TLB answers captured in the first cycle after accept are the ones reported.
      if (m_active && d == 1) begin
        m_found = tlb_bus.s_found;
        m_idx   = tlb_bus.s_index;
        m_rent  = tlb_bus.r_entry;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cp0_tlb_seq.md
Name: cp0_tlb_seq

Overview:
Multi-cycle sequencer for the TLB-management instructions TLBP, TLBR and TLBWI. It issues these from the WB stage and sits between the CP0 register file and the TLB.
- Drives the TLB search, read and write ports from the CP0 EntryHi, EntryLo0/1 and Index registers.
- Returns results to CP0 as single-cycle tlbp/tlbr update pulses.
- Stalls the pipeline while busy, then requests a refetch of the instruction after the TLB op so that later fetches use the new mapping.

Parameters:
TLBNUM, 16, number of TLB entries
IDX_W, 4, index width (log2 TLBNUM)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op_valid  in  1  TLB instruction present in WB
op_type  in  2  0=TLBP, 1=TLBR, 2=TLBWI, 3=reserved (treated as no-op)
op_pc  in  32  PC of the TLB instruction
wb_ex  in  1  exception/interrupt being taken in WB this cycle
c0_entryhi  in  32  CP0 EntryHi
c0_entrylo0  in  32  CP0 EntryLo0
c0_entrylo1  in  32  CP0 EntryLo1
c0_index  in  32  CP0 Index
s_vpn2  out  19  TLB search VPN2
s_asid  out  8  TLB search ASID
s_found  in  1  TLB search hit (combinational from s_vpn2/s_asid)
s_index  in  IDX_W  TLB search hit index
r_index  out  IDX_W  TLB read index
r_entry  in  78  TLB read data (combinational), packed entry
w_we  out  1  TLB write enable
w_index  out  IDX_W  TLB write index
w_entry  out  78  TLB write data, packed entry
cp0_tlbp  out  1  pulse: CP0 updates Index.P/Index
cp0_tlbp_found  out  1  valid with cp0_tlbp
cp0_index  out  IDX_W  valid with cp0_tlbp
cp0_tlbr  out  1  pulse: CP0 loads EntryHi/EntryLo0/EntryLo1 from cp0_rentry
cp0_rentry  out  78  valid with cp0_tlbr
busy  out  1  stall WB and earlier stages
refetch  out  1  pulse: flush pipeline and restart fetch at refetch_pc
refetch_pc  out  32  op_pc+4 (latched)

Behaviour:
Packed entry layout, MSB first: vpn2[18:0], asid[7:0], g, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1.

FSM states: IDLE, EXEC, COMMIT, REFETCH. State is registered. Reset drives state to IDLE and every output register to 0.
- Accept: in IDLE, when op_valid && !wb_ex && op_type!=3, latch op_type and op_pc+4, then go to EXEC. If op_valid && wb_ex in the same cycle, the op is dropped. op_type=3 is ignored.
- EXEC, TLBP: drive s_vpn2=c0_entryhi[31:13] and s_asid=c0_entryhi[7:0]. Register s_found/s_index at the clock edge, then go to COMMIT.
- EXEC, TLBR: drive r_index=c0_index[IDX_W-1:0]. Register r_entry, then go to COMMIT.
- EXEC, TLBWI: w_we=1 for exactly this cycle.
  - w_index=c0_index[IDX_W-1:0].
  - w_entry is built from the CP0 registers:
    - vpn2=entryhi[31:13], asid=entryhi[7:0]
    - g=lo0[0]&lo1[0]
    - pfnN=loN[25:6], cN=loN[5:3], dN=loN[2], vN=loN[1]
  - Go directly to REFETCH (COMMIT is skipped).
- COMMIT: one-cycle pulse of cp0_tlbp (with the registered found/index) or cp0_tlbr (with the registered entry). Go to REFETCH.
- REFETCH: refetch=1 for one cycle with refetch_pc stable. Go to IDLE.
- Latency from accept to refetch pulse: TLBP and TLBR take 3 cycles, TLBWI takes 2.

Outputs in non-EXEC states:
- s_* and r_index are driven from the CP0 registers continuously; they are harmless when idle.
- w_we=0 outside EXEC/TLBWI.

busy:
- busy=1 in EXEC, COMMIT and REFETCH.
- busy is also combinationally 1 in the accept cycle, so WB holds the instruction.
- The next op is accepted no earlier than the cycle after REFETCH.

Other rules:
- wb_ex while not IDLE is ignored. The op completes, because it is the oldest instruction.
- op_valid while busy is ignored; the stall guarantees it is the same instruction.
- Reset asserted in any state returns the FSM to IDLE next cycle. No pulse is emitted and w_we=0 in that cycle.
- s_index and r_index truncate to IDX_W.

Decomposition:
Shared package holds:
- OP_TLBP/OP_TLBR/OP_TLBWI encodings
- state encodings
- ENTRY_W=78 and the field offsets of the packed entry

Sub-module tlb_entry_pack: combinational packing from EntryHi/Lo0/Lo1 to a 78-bit entry. It is reused by CP0-side unpacking checks.

Test Plan:
- TLBP hit: EntryHi=0x00402005, s_found=1, s_index=7 → cycle 2: cp0_tlbp=1, found=1, index=7; cycle 3: refetch=1, refetch_pc=op_pc+4.
- TLBP miss: s_found=0 → cp0_tlbp=1, cp0_tlbp_found=0; no w_we and no cp0_tlbr at any point.
- TLBWI: Index=3, EntryHi=0x12346001, Lo0=0x0000_1047, Lo1=0x0000_1087 → one cycle of w_we=1, w_index=3, vpn2=0x091A3, asid=0x01, g=1, pfn0=0x41, pfn1=0x42; refetch next cycle.
- TLBR: Index=5, r_entry pattern 0x2A..A → cp0_tlbr pulse carries the identical 78-bit value; busy is high for exactly 3 cycles after accept.
- op_valid with wb_ex in the same cycle → no state change and busy=0. wb_ex raised during EXEC → op still completes.
- Reset asserted in COMMIT → no cp0_tlbp/refetch pulse; IDLE with all outputs 0 the next cycle; the next op is accepted normally.
